// File: rtl/counter_share_ctrl_if.sv
// Interface bundling the requester handshake and shared-counter signals of
// counter_share_ctrl. The controller uses the slave modport; the requesters
// together with the shared counter sit on the master side.
interface counter_share_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [1:0]       x;
  logic [WIDTH-1:0] count;
  logic             cnt_clr_n;
  logic             cnt_en;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic             err;

  // Requesters plus shared counter: drive requests, enables and the count value.
  modport master (
    output req, x, count,
    input  cnt_clr_n, cnt_en, gnt, done, busy, err
  );

  // Controller: arbitrates and sequences the shared counter.
  modport slave (
    input  req, x, count,
    output cnt_clr_n, cnt_en, gnt, done, busy, err
  );
endinterface

// File: rtl/counter_share_ctrl.sv
// counter_share_ctrl: shares one WIDTH-bit up-counter between two requesters.
// Round-robin arbitration, one-cycle counter clear, count gated by the owner's
// x bit, one-cycle done pulse when the count reaches all-ones.
// Optional feature: define HOLD_TIMEOUT_EN to abort a RUN phase that lasts
// TIMEOUT cycles without reaching terminal count (err pulse, owner loses priority).
module counter_share_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input logic                 clk,
  input logic                 clear,
  counter_share_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    CLR  = 4'b0010,
    RUN  = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t     state;
  logic       owner;
  logic       rr_ptr;
  logic [1:0] gnt_q;
  logic [1:0] done_q;
  logic       busy_q;
  logic       clr_n_q;
  logic       term;
  logic       pick;
  logic       tmo_hit;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Terminal count: the shared counter holds all-ones.
  assign term = (bus.count == {WIDTH{1'b1}});

  // A lone request wins outright; a tie goes to the round-robin pointer.
  assign pick = (bus.req == 2'b11) ? rr_ptr : bus.req[1];

`ifdef HOLD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo;

  // RUN-cycle counter: zeroed in CLR so it starts at 0 on the first RUN cycle.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      tmo <= '0;
    end else if (state == CLR) begin
      tmo <= '0;
    end else if (state == RUN) begin
      tmo <= tmo + TW'(1);
    end
  end

  // Last permitted RUN cycle (the TIMEOUT-th one).
  assign tmo_hit = (tmo == TW'(TIMEOUT - 1));
  // Timeout only when terminal count has not been reached in the same cycle.
  assign bus.err = (state == RUN) && tmo_hit && !term;
`else
  // Without the timeout feature this comparison is constant 0.
  assign tmo_hit = (TIMEOUT < 0);
  assign bus.err = 1'b0;
`endif

  // Count enable follows the owner's x live, and stops at all-ones so the
  // counter never wraps while this block controls it.
  assign bus.cnt_en = (state == RUN) && bus.x[owner] && !term;

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.cnt_clr_n = clr_n_q;

  // Sequencer: arbitration, counter clear, run/abort/timeout and completion,
  // with the Moore outputs registered alongside the state they belong to.
  // NOTE: every register here uses non-blocking assignment so all updates take
  // effect together at the edge; blocking assignment would let later branches
  // see partially-updated state and simulate differently from the hardware.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      owner   <= 1'b0;
      rr_ptr  <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      clr_n_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state   <= CLR;
            owner   <= pick;
            gnt_q   <= onehot(pick);
            busy_q  <= 1'b1;
            clr_n_q <= 1'b0;
          end
        end
        CLR: begin
          state   <= RUN;
          clr_n_q <= 1'b1;
        end
        RUN: begin
          if (term) begin
            // Completion beats a simultaneous request drop or timeout.
            state  <= DONE;
            done_q <= onehot(owner);
          end else if (tmo_hit) begin
            // Hung owner: abort and hand priority to the other requester.
            state  <= IDLE;
            rr_ptr <= ~owner;
            gnt_q  <= 2'b00;
            busy_q <= 1'b0;
          end else if (!bus.req[owner]) begin
            // Owner withdrew: abort without done, priority unchanged.
            state  <= IDLE;
            gnt_q  <= 2'b00;
            busy_q <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          rr_ptr <= ~owner;
          done_q <= 2'b00;
          gnt_q  <= 2'b00;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          gnt_q   <= 2'b00;
          done_q  <= 2'b00;
          busy_q  <= 1'b0;
          clr_n_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Testbench for counter_share_ctrl. Models the shared 4-bit counter, drives
// directed and randomized transactions, and predicts each transaction's grant,
// completion/timeout and return-to-idle cycles from the transaction's x
// sequence. A monitor pops those predictions when the DUT shows the events.
// Build with +define+HOLD_TIMEOUT_EN to exercise the timeout feature.
`timescale 1ns/1ps
module tb_counter_share_ctrl;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 32;
  localparam int TERM    = (1 << WIDTH) - 1;  // enabled cycles from 0 to all-ones
  localparam int MAXPOS  = 64;                // RUN positions generated per txn
  localparam int NEVER   = 1 << 30;

  typedef struct {
    int         cyc;
    logic [1:0] who;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [1:0] who;
    bit         is_err;
  } fin_t;

  logic clk   = 1'b0;
  logic clear = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;
  int   prio  = 0;   // requester that wins the next tie

  ev_t  grant_q[$];
  fin_t fin_q[$];
  int   end_q[$];

  counter_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

  counter_share_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared counter: active-low synchronous clear, increment enable.
  always @(posedge clk or negedge clear) begin
    if (!clear)              bus.count <= 4'h9;
    else if (!bus.cnt_clr_n) bus.count <= '0;
    else if (bus.cnt_en)     bus.count <= bus.count + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT events against the predicted queues.
  ev_t  mon_g;
  fin_t mon_f;
  int   mon_e;
  logic clr_exp;
  logic [1:0] prev_gnt  = 2'b00;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      clr_exp = !(grant_q.size() > 0 && grant_q[0].cyc == cyc);
      check("cnt_clr_n", bus.cnt_clr_n, clr_exp);
      if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
        if (grant_q.size() == 0) check("grant_unexpected", bus.gnt, 2'b00);
        else begin
          mon_g = grant_q.pop_front();
          check("grant_owner", bus.gnt, mon_g.who);
          check("grant_cycle", cyc, mon_g.cyc);
        end
      end
      if (bus.done != 2'b00 || bus.err) begin
        if (fin_q.size() == 0) check("finish_unexpected", {bus.err, bus.done}, 3'b000);
        else begin
          mon_f = fin_q.pop_front();
          check("done", bus.done, mon_f.is_err ? 2'b00 : mon_f.who);
          check("err", bus.err, mon_f.is_err);
          check("finish_cycle", cyc, mon_f.cyc);
        end
      end
      if (prev_busy && !bus.busy) begin
        if (end_q.size() == 0) check("idle_unexpected", bus.busy, 1'b1);
        else begin
          mon_e = end_q.pop_front();
          check("idle_cycle", cyc, mon_e);
        end
      end
      if (bus.count == TERM) check("no_wrap_en", bus.cnt_en, 1'b0);
    end
    prev_gnt  <= bus.gnt;
    prev_busy <= bus.busy;
  end

  // One transaction, started in an IDLE cycle. mode: 0 x always on,
  // 1 five on / four off / on, 2 random 75%, 3 random 25%, 4 long stall.
  // apos_in: RUN position where the owner drops req (-1 = never).
  task automatic run_txn(input logic [1:0] pat, input int mode, input int apos_in);
    bit   xs[MAXPOS];
    int   owner, p, ones, zpos, tpos, apos, e, c0;
    logic [1:0] rv, xv;
    c0    = cyc;
    owner = (pat == 2'b11) ? prio : (pat[1] ? 1 : 0);
    for (int j = 0; j < MAXPOS; j++) begin
      case (mode)
        0:       xs[j] = 1'b1;
        1:       xs[j] = (j < 5 || j >= 9);
        2:       xs[j] = ($urandom_range(0, 3) != 0);
        3:       xs[j] = ($urandom_range(0, 3) == 0);
        default: xs[j] = 1'b0;
      endcase
      if (j >= MAXPOS - TERM) xs[j] = 1'b1;
    end
    // Position of the TERM-th enabled cycle; Z is seen one position later.
    ones = 0;
    p    = 0;
    for (int j = 0; j < MAXPOS; j++) begin
      if (xs[j] && ones < TERM) begin
        ones++;
        if (ones == TERM) p = j;
      end
    end
    zpos = p + 1;
`ifdef HOLD_TIMEOUT_EN
    tpos = TIMEOUT - 1;
`else
    tpos = NEVER;
`endif
    apos = (apos_in < 0) ? NEVER : apos_in;
    e = zpos;
    if (tpos < e) e = tpos;
    if (apos < e) e = apos;

    grant_q.push_back('{cyc: c0 + 1, who: oh(owner)});
    if (e == zpos) begin
      fin_q.push_back('{cyc: c0 + 2 + e + 1, who: oh(owner), is_err: 1'b0});
      end_q.push_back(c0 + 2 + e + 2);
      prio = 1 - owner;
    end else if (e == tpos) begin
      fin_q.push_back('{cyc: c0 + 2 + e, who: oh(owner), is_err: 1'b1});
      end_q.push_back(c0 + 2 + e + 1);
      prio = 1 - owner;
    end else begin
      end_q.push_back(c0 + 2 + e + 1);
    end

    bus.req = pat;
    bus.x   = 2'($urandom());
    step();                                   // CLR
    bus.x   = 2'($urandom());
    for (int j = 0; j <= e; j++) begin
      step();                                 // RUN position j
      rv        = 2'($urandom());
      rv[owner] = (j != apos);
      xv        = 2'($urandom());
      xv[owner] = xs[j];
      bus.req   = rv;
      bus.x     = xv;
    end
    if (e == zpos) begin
      step();                                 // DONE
      rv        = 2'($urandom());
      rv[owner] = 1'b1;
      bus.req   = rv;
    end
    step();                                   // first IDLE cycle
    bus.req = 2'b00;
  endtask

  initial begin
    int gap;
    bus.req = 2'b00;
    bus.x   = 2'b00;
    repeat (2) step();

    // Start a run, then reset in the middle of it: outputs drop at once.
    clear   = 1'b1;
    bus.req = 2'b01;
    bus.x   = 2'b01;
    repeat (6) step();
    check("busy_mid_run", bus.busy, 1'b1);
    clear = 1'b0;
    #1;
    check("rst_gnt", bus.gnt, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 2'b00);
    check("rst_err", bus.err, 1'b0);
    check("rst_cnt_clr_n", bus.cnt_clr_n, 1'b1);
    check("rst_cnt_en", bus.cnt_en, 1'b0);

    // Held in reset with both requesting.
    bus.req = 2'b11;
    bus.x   = 2'b11;
    repeat (2) begin
      step();
      check("rst_hold_gnt", bus.gnt, 2'b00);
      check("rst_hold_busy", bus.busy, 1'b0);
      check("rst_hold_done", bus.done, 2'b00);
    end
    clear  = 1'b1;
    mon_on = 1'b1;

    run_txn(2'b11, 0, -1);   // tie after reset: requester 0, done 18 cycles later
    run_txn(2'b11, 0, -1);   // tie again: requester 1 next
    run_txn(2'b01, 0, 6);    // drop at count 6: abort
    run_txn(2'b11, 0, -1);   // priority unchanged by abort: requester 0
    run_txn(2'b01, 1, -1);   // 4-cycle stall at count 5
    run_txn(2'b10, 4, -1);   // long stall: timeout when enabled

    for (int t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        bus.req = 2'b00;
        bus.x   = 2'($urandom());
        step();
      end
      run_txn(2'($urandom_range(1, 3)),
              ($urandom_range(0, 4) == 0) ? 3 : 2,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1);
    end

    repeat (5) step();
    check("pending_grants", grant_q.size(), 0);
    check("pending_finishes", fin_q.size(), 0);
    check("pending_idles", end_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
